// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: sub-block handshakes plus the shared SDRAM command/DQ path.
interface sdram_arbiter_if;
    logic        flag_init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        ref_req;
    logic        flag_ref_end;
    logic [3:0]  ref_cmd;
    logic [11:0] ref_addr;
    logic        wr_req;
    logic        flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_bank;
    logic [15:0] wr_data;
    logic        rd_req;
    logic        flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        ref_en;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic [4:0]  arb_state;
    logic        ref_ovf;
    logic        wd_err;
    modport master (
        output flag_init_end, init_cmd, init_addr, ref_req, flag_ref_end, ref_cmd, ref_addr,
               wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
               rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        input  ref_en, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_bank, dq_oe, dq_out,
               arb_state, ref_ovf, wd_err
    );
    modport slave (
        input  flag_init_end, init_cmd, init_addr, ref_req, flag_ref_end, ref_cmd, ref_addr,
               wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
               rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        output ref_en, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_bank, dq_oe, dq_out,
               arb_state, ref_ovf, wd_err
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: refresh-first, round-robin wr/rd arbiter with per-burst watchdog.
module sdram_arbiter #(
    parameter int TO_CYCLES = 1000
) (
    input logic          clk,
    input logic          rst_n,
    sdram_arbiter_if.slave bus
);
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        ARBIT = 5'b00010,
        AREF  = 5'b00100,
        WRITE = 5'b01000,
        READ  = 5'b10000
    } state_t;
    state_t      state;
    logic        ref_pend;
    logic        last_rd;
    logic [15:0] wd_cnt;
    logic        wd_hit;
    logic        service;
    logic        enter_aref;
    assign wd_hit     = wd_cnt == 16'(TO_CYCLES - 1);
    assign service    = state == AREF || state == WRITE || state == READ;
    assign enter_aref = state == ARBIT && (ref_pend || bus.ref_req);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.ref_en  <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.rd_en   <= 1'b0;
            ref_pend    <= 1'b0;
            last_rd     <= 1'b1;
            wd_cnt      <= '0;
            bus.ref_ovf <= 1'b0;
            bus.wd_err  <= 1'b0;
        end else begin
            bus.ref_en  <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.rd_en   <= 1'b0;
            wd_cnt      <= service ? wd_cnt + 16'd1 : '0;
            ref_pend    <= enter_aref ? 1'b0 : (bus.ref_req || ref_pend);
            if (bus.ref_req && ref_pend && !enter_aref) bus.ref_ovf <= 1'b1;
            case (state)
                IDLE: if (bus.flag_init_end) state <= ARBIT;
                ARBIT: begin
                    if (ref_pend || bus.ref_req) begin
                        state      <= AREF;
                        bus.ref_en <= 1'b1;
                    end else if (bus.wr_req && (!bus.rd_req || last_rd)) begin
                        state     <= WRITE;
                        bus.wr_en <= 1'b1;
                        last_rd   <= 1'b0;
                    end else if (bus.rd_req) begin
                        state     <= READ;
                        bus.rd_en <= 1'b1;
                        last_rd   <= 1'b1;
                    end
                end
                AREF: if (bus.flag_ref_end || wd_hit) begin
                    state <= ARBIT;
                    if (!bus.flag_ref_end) bus.wd_err <= 1'b1;
                end
                WRITE: if (bus.flag_wr_end || wd_hit) begin
                    state <= ARBIT;
                    if (!bus.flag_wr_end) bus.wd_err <= 1'b1;
                end
                READ: if (bus.flag_rd_end || wd_hit) begin
                    state <= ARBIT;
                    if (!bus.flag_rd_end) bus.wd_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        bus.sdram_cmd  = 4'b0111;
        bus.sdram_addr = '0;
        bus.sdram_bank = '0;
        case (state)
            IDLE:  begin bus.sdram_cmd = bus.init_cmd; bus.sdram_addr = bus.init_addr; end
            AREF:  begin bus.sdram_cmd = bus.ref_cmd;  bus.sdram_addr = bus.ref_addr;  end
            WRITE: begin bus.sdram_cmd = bus.wr_cmd;   bus.sdram_addr = bus.wr_addr; bus.sdram_bank = bus.wr_bank; end
            READ:  begin bus.sdram_cmd = bus.rd_cmd;   bus.sdram_addr = bus.rd_addr; bus.sdram_bank = bus.rd_bank; end
            default: ;
        endcase
    end
    assign bus.dq_oe     = state == WRITE;
    assign bus.dq_out    = state == WRITE ? bus.wr_data : '0;
    assign bus.arb_state = state;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed sequence covering init, fairness, refresh, watchdog, reset.
module tb_sdram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    sdram_arbiter_if bus ();
    sdram_arbiter #(.TO_CYCLES(20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    localparam logic [4:0] S_IDLE = 5'b00001, S_ARBIT = 5'b00010, S_AREF = 5'b00100,
                           S_WRITE = 5'b01000, S_READ = 5'b10000;
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic grants(input string tag, input logic r, input logic w, input logic d);
        chk({tag, "_ref_en"}, 32'(bus.ref_en), 32'(r));
        chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'(w));
        chk({tag, "_rd_en"}, 32'(bus.rd_en), 32'(d));
    endtask
    initial begin
        bus.flag_init_end = 0; bus.ref_req = 0; bus.flag_ref_end = 0;
        bus.wr_req = 0; bus.flag_wr_end = 0; bus.rd_req = 0; bus.flag_rd_end = 0;
        bus.init_cmd = 4'b0010; bus.init_addr = 12'h400;
        bus.ref_cmd = 4'b0001;  bus.ref_addr = 12'h0AA;
        bus.wr_cmd = 4'b0100;   bus.wr_addr = 12'h123; bus.wr_bank = 2'd2; bus.wr_data = 16'hBEEF;
        bus.rd_cmd = 4'b0101;   bus.rd_addr = 12'h456; bus.rd_bank = 2'd1;
        #12;
        chk("rst_state", 32'(bus.arb_state), 32'(S_IDLE));
        grants("rst", 0, 0, 0);
        chk("rst_cmd", 32'(bus.sdram_cmd), 32'h2);
        chk("rst_addr", 32'(bus.sdram_addr), 32'h400);
        chk("rst_bank", 32'(bus.sdram_bank), 0);
        chk("rst_dq_oe", 32'(bus.dq_oe), 0);
        chk("rst_ovf", 32'(bus.ref_ovf), 0);
        chk("rst_wd", 32'(bus.wd_err), 0);
        tick();
        rst_n = 1;
        tick(8);
        chk("idle_hold", 32'(bus.arb_state), 32'(S_IDLE));
        grants("idle", 0, 0, 0);
        bus.flag_init_end = 1;
        tick();
        bus.flag_init_end = 0;
        chk("init_arbit", 32'(bus.arb_state), 32'(S_ARBIT));
        chk("arbit_nop", 32'(bus.sdram_cmd), 32'h7);
        chk("arbit_addr", 32'(bus.sdram_addr), 0);
        tick(2);
        grants("arbit_idle", 0, 0, 0);
        bus.wr_req = 1; bus.rd_req = 1;
        tick();
        chk("tie1_state", 32'(bus.arb_state), 32'(S_WRITE));
        grants("tie1", 0, 1, 0);
        chk("w_dq_oe", 32'(bus.dq_oe), 1);
        chk("w_dq_out", 32'(bus.dq_out), 32'hBEEF);
        chk("w_cmd", 32'(bus.sdram_cmd), 32'h4);
        chk("w_addr", 32'(bus.sdram_addr), 32'h123);
        chk("w_bank", 32'(bus.sdram_bank), 2);
        tick();
        grants("tie1_drop", 0, 0, 0);
        bus.flag_rd_end = 1;
        tick();
        bus.flag_rd_end = 0;
        chk("foreign_end_ignored", 32'(bus.arb_state), 32'(S_WRITE));
        tick(5);
        bus.flag_wr_end = 1;
        tick();
        bus.flag_wr_end = 0;
        chk("tie1_end", 32'(bus.arb_state), 32'(S_ARBIT));
        chk("arbit_dq_oe", 32'(bus.dq_oe), 0);
        grants("dwell", 0, 0, 0);
        tick();
        chk("tie2_state", 32'(bus.arb_state), 32'(S_READ));
        grants("tie2", 0, 0, 1);
        chk("r_cmd", 32'(bus.sdram_cmd), 32'h5);
        chk("r_addr", 32'(bus.sdram_addr), 32'h456);
        chk("r_bank", 32'(bus.sdram_bank), 1);
        chk("r_dq_oe", 32'(bus.dq_oe), 0);
        chk("r_dq_out", 32'(bus.dq_out), 0);
        tick(7);
        bus.flag_rd_end = 1;
        tick();
        bus.flag_rd_end = 0;
        chk("tie2_end", 32'(bus.arb_state), 32'(S_ARBIT));
        tick();
        chk("tie3_state", 32'(bus.arb_state), 32'(S_WRITE));
        grants("tie3", 0, 1, 0);
        tick(2);
        bus.ref_req = 1;
        tick();
        bus.ref_req = 0;
        chk("ref_in_write_held", 32'(bus.arb_state), 32'(S_WRITE));
        grants("ref_in_write", 0, 0, 0);
        tick(3);
        bus.flag_wr_end = 1;
        tick();
        bus.flag_wr_end = 0;
        tick();
        chk("ref_prio_state", 32'(bus.arb_state), 32'(S_AREF));
        grants("ref_prio", 1, 0, 0);
        chk("aref_cmd", 32'(bus.sdram_cmd), 32'h1);
        chk("aref_addr", 32'(bus.sdram_addr), 32'h0AA);
        tick(2);
        bus.flag_ref_end = 1;
        tick();
        bus.flag_ref_end = 0;
        chk("aref_end", 32'(bus.arb_state), 32'(S_ARBIT));
        tick();
        chk("pend_cleared_read", 32'(bus.arb_state), 32'(S_READ));
        grants("after_ref", 0, 0, 1);
        tick();
        bus.ref_req = 1;
        tick();
        bus.ref_req = 0;
        chk("ovf_first_pulse", 32'(bus.ref_ovf), 0);
        tick(2);
        bus.ref_req = 1;
        tick();
        bus.ref_req = 0;
        chk("ovf_set", 32'(bus.ref_ovf), 1);
        tick();
        bus.flag_rd_end = 1;
        tick();
        bus.flag_rd_end = 0;
        tick();
        chk("ovf_aref", 32'(bus.arb_state), 32'(S_AREF));
        bus.flag_ref_end = 1;
        tick();
        bus.flag_ref_end = 0;
        tick();
        chk("single_aref", 32'(bus.arb_state), 32'(S_WRITE));
        grants("wd_grant", 0, 1, 0);
        chk("ovf_sticky", 32'(bus.ref_ovf), 1);
        chk("wd_clear", 32'(bus.wd_err), 0);
        tick(19);
        chk("wd_not_yet", 32'(bus.arb_state), 32'(S_WRITE));
        tick();
        chk("wd_exit", 32'(bus.arb_state), 32'(S_ARBIT));
        chk("wd_err_set", 32'(bus.wd_err), 1);
        tick();
        chk("post_wd_read", 32'(bus.arb_state), 32'(S_READ));
        grants("post_wd", 0, 0, 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_state", 32'(bus.arb_state), 32'(S_IDLE));
        chk("async_rst_rd_en", 32'(bus.rd_en), 0);
        chk("async_rst_wd", 32'(bus.wd_err), 0);
        chk("async_rst_ovf", 32'(bus.ref_ovf), 0);
        chk("async_rst_cmd", 32'(bus.sdram_cmd), 32'h2);
        rst_n = 1;
        tick(3);
        chk("rst_wait_init", 32'(bus.arb_state), 32'(S_IDLE));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
